// File: rtl/vend_pkg.sv
// Shared definitions for the multi-category vending controller:
// FSM state codes, selection error codes and selector width helpers.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CREDIT   = 3'd1,
    ST_CHECK    = 3'd2,
    ST_PAY_MORE = 3'd3,
    ST_CHANGE   = 3'd4,
    ST_DISPENSE = 3'd5,
    ST_REFUND   = 3'd6
  } vend_state_e;

  typedef enum logic [1:0] {
    SEL_OK       = 2'b00,
    SEL_INVALID  = 2'b01,
    SEL_NO_STOCK = 2'b10
  } sel_err_e;

  // A selector always needs at least one bit, even for a single category.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_N_CAT   = 2;
  localparam int DEF_N_ITEMS = 10;
  localparam int DEF_CAT_W   = sel_width(DEF_N_CAT);
  localparam int DEF_ITEM_W  = sel_width(DEF_N_ITEMS);

endpackage

// File: rtl/vend_inventory.sv
// Price/stock table of N_CAT x N_ITEMS entries with a combinational read,
// one configuration write port and one stock-decrement port.
module vend_inventory
  import vend_pkg::*;
#(
  parameter int N_CAT   = DEF_N_CAT,
  parameter int N_ITEMS = DEF_N_ITEMS,
  parameter int CW      = 10,
  parameter int STOCK_W = 4,
  parameter int CAT_W   = sel_width(N_CAT),
  parameter int ITEM_W  = sel_width(N_ITEMS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               we_i,
  input  logic [CAT_W-1:0]   wr_cat_i,
  input  logic [ITEM_W-1:0]  wr_item_i,
  input  logic [CW-1:0]      wr_price_i,
  input  logic [STOCK_W-1:0] wr_stock_i,
  input  logic               dec_i,
  input  logic [CAT_W-1:0]   dec_cat_i,
  input  logic [ITEM_W-1:0]  dec_item_i,
  input  logic [CAT_W-1:0]   rd_cat_i,
  input  logic [ITEM_W-1:0]  rd_item_i,
  output logic [CW-1:0]      rd_price_o,
  output logic [STOCK_W-1:0] rd_stock_o
);

  logic [CW-1:0]      price_q [N_CAT][N_ITEMS];
  logic [STOCK_W-1:0] stock_q [N_CAT][N_ITEMS];

  // A decrement on the same entry as a write wins and suppresses the write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < N_CAT; c++) begin
        for (int i = 0; i < N_ITEMS; i++) begin
          price_q[c][i] <= '0;
          stock_q[c][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < N_CAT; c++) begin
        for (int i = 0; i < N_ITEMS; i++) begin
          if (dec_i && int'(dec_cat_i) == c && int'(dec_item_i) == i) begin
            if (stock_q[c][i] != '0) stock_q[c][i] <= stock_q[c][i] - STOCK_W'(1);
          end else if (we_i && int'(wr_cat_i) == c && int'(wr_item_i) == i) begin
            price_q[c][i] <= wr_price_i;
            stock_q[c][i] <= wr_stock_i;
          end
        end
      end
    end
  end

  always_comb begin
    rd_price_o = '0;
    rd_stock_o = '0;
    for (int c = 0; c < N_CAT; c++) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (int'(rd_cat_i) == c && int'(rd_item_i) == i) begin
          rd_price_o = price_q[c][i];
          rd_stock_o = stock_q[c][i];
        end
      end
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-category vending controller: coin credit, table-checked selection, change,
// dispense and refund. Define VEND_TIMEOUT_EN to refund after TIMEOUT quiet cycles.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int N_CAT   = DEF_N_CAT,
  parameter int N_ITEMS = DEF_N_ITEMS,
  parameter int CW      = 10,
  parameter int STOCK_W = 4,
  parameter int TIMEOUT = 15,
  localparam int CAT_W  = sel_width(N_CAT),
  localparam int ITEM_W = sel_width(N_ITEMS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               coin_valid_i,
  input  logic [CW-1:0]      coin_value_i,
  input  logic               sel_valid_i,
  input  logic [CAT_W-1:0]   cat_sel_i,
  input  logic [ITEM_W-1:0]  item_sel_i,
  input  logic               cancel_i,
  input  logic               cfg_we_i,
  input  logic [CAT_W-1:0]   cfg_cat_i,
  input  logic [ITEM_W-1:0]  cfg_item_i,
  input  logic [CW-1:0]      cfg_price_i,
  input  logic [STOCK_W-1:0] cfg_stock_i,
  output logic [CW-1:0]      credit_o,
  output logic               coin_reject_o,
  output logic [1:0]         sel_err_o,
  output logic               change_valid_o,
  output logic [CW-1:0]      change_amount_o,
  output logic               refund_valid_o,
  output logic [CW-1:0]      refund_amount_o,
  output logic               dispense_valid_o,
  output logic [CAT_W-1:0]   dispense_cat_o,
  output logic [ITEM_W-1:0]  dispense_item_o,
  output logic [2:0]         state_o
);

  vend_state_e        state_q, state_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic [CAT_W-1:0]   cat_q, cat_d;
  logic [ITEM_W-1:0]  item_q, item_d;
  logic               coin_reject_q, coin_reject_d;
  logic [CW-1:0]      rd_price;
  logic [STOCK_W-1:0] rd_stock;
  logic [CW:0]        coin_sum;
  logic               coin_ok;
  logic [1:0]         sel_code;

  vend_inventory #(
    .N_CAT(N_CAT), .N_ITEMS(N_ITEMS), .CW(CW), .STOCK_W(STOCK_W),
    .CAT_W(CAT_W), .ITEM_W(ITEM_W)
  ) u_inventory (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .we_i       (cfg_we_i && state_q == ST_IDLE),
    .wr_cat_i   (cfg_cat_i),
    .wr_item_i  (cfg_item_i),
    .wr_price_i (cfg_price_i),
    .wr_stock_i (cfg_stock_i),
    .dec_i      (state_q == ST_DISPENSE),
    .dec_cat_i  (cat_q),
    .dec_item_i (item_q),
    .rd_cat_i   (cat_q),
    .rd_item_i  (item_q),
    .rd_price_o (rd_price),
    .rd_stock_o (rd_stock)
  );

  // The extra sum bit flags a coin that would overflow the credit register.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value_i};
  assign coin_ok  = coin_valid_i && !coin_sum[CW] &&
                    (state_q == ST_IDLE || state_q == ST_CREDIT || state_q == ST_PAY_MORE);

  always_comb begin
    sel_code = SEL_OK;
    if (item_q == '0 || int'(item_q) >= N_ITEMS || int'(cat_q) >= N_CAT || rd_price == '0)
      sel_code = SEL_INVALID;
    else if (rd_stock == '0)
      sel_code = SEL_NO_STOCK;
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] timer_q, timer_d;
  logic            quiet;

  assign quiet = (state_q == ST_CREDIT || state_q == ST_PAY_MORE) &&
                 !coin_ok && !sel_valid_i && !cancel_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = coin_ok ? coin_sum[CW-1:0] : credit_q;
    cat_d         = cat_q;
    item_d        = item_q;
    coin_reject_d = coin_valid_i && !coin_ok;
    case (state_q)
      ST_IDLE:     if (coin_ok) state_d = ST_CREDIT;
      ST_CREDIT: begin
        if (cancel_i) begin
          state_d = ST_REFUND;
        end else if (sel_valid_i) begin
          cat_d   = cat_sel_i;
          item_d  = item_sel_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sel_code != SEL_OK)      state_d = ST_CREDIT;
        else if (credit_q > rd_price) state_d = ST_CHANGE;
        else if (credit_q == rd_price) state_d = ST_DISPENSE;
        else                          state_d = ST_PAY_MORE;
      end
      ST_PAY_MORE: begin
        if (cancel_i)     state_d = ST_REFUND;
        else if (coin_ok) state_d = ST_CHECK;
      end
      ST_CHANGE:   state_d = ST_DISPENSE;
      ST_DISPENSE: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
      ST_REFUND: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
`ifdef VEND_TIMEOUT_EN
    // A quiet cycle is one where nothing else moves the FSM, so the counter is cleared on any exit.
    timer_d = '0;
    if (quiet) begin
      if (timer_q == TO_W'(TIMEOUT - 1)) state_d = ST_REFUND;
      else                              timer_d = timer_q + TO_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      cat_q         <= '0;
      item_q        <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      cat_q         <= cat_d;
      item_q        <= item_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign state_o          = state_q;
  assign credit_o         = credit_q;
  assign coin_reject_o    = coin_reject_q;
  assign sel_err_o        = (state_q == ST_CHECK) ? sel_code : SEL_OK;
  assign change_valid_o   = (state_q == ST_CHANGE);
  assign change_amount_o  = (state_q == ST_CHANGE) ? credit_q - rd_price : '0;
  assign refund_valid_o   = (state_q == ST_REFUND);
  assign refund_amount_o  = (state_q == ST_REFUND) ? credit_q : '0;
  assign dispense_valid_o = (state_q == ST_DISPENSE);
  assign dispense_cat_o   = (state_q == ST_DISPENSE) ? cat_q : '0;
  assign dispense_item_o  = (state_q == ST_DISPENSE) ? item_q : '0;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: directed walk through the vending scenarios,
// then randomized traffic compared every cycle against a behavioural model.
module tb_vend_ctrl_multi;
  import vend_pkg::*;

  localparam int N_CAT      = DEF_N_CAT;
  localparam int N_ITEMS    = DEF_N_ITEMS;
  localparam int CW         = 10;
  localparam int STOCK_W    = 4;
  localparam int CAT_W      = DEF_CAT_W;
  localparam int ITEM_W     = DEF_ITEM_W;
  localparam int MAX_CREDIT = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               coinValid, selValid, cancel, cfgWe;
  logic [CW-1:0]      coinValue, cfgPrice;
  logic [CAT_W-1:0]   catSel, cfgCat;
  logic [ITEM_W-1:0]  itemSel, cfgItem;
  logic [STOCK_W-1:0] cfgStock;
  logic [CW-1:0]      credit, changeAmount, refundAmount;
  logic               coinReject, changeValid, refundValid, dispenseValid;
  logic [1:0]         selErr;
  logic [CAT_W-1:0]   dispenseCat;
  logic [ITEM_W-1:0]  dispenseItem;
  logic [2:0]         state;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  vend_ctrl_multi #(
    .N_CAT(N_CAT), .N_ITEMS(N_ITEMS), .CW(CW), .STOCK_W(STOCK_W), .TIMEOUT(15)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .coin_valid_i(coinValid), .coin_value_i(coinValue),
    .sel_valid_i(selValid), .cat_sel_i(catSel), .item_sel_i(itemSel),
    .cancel_i(cancel),
    .cfg_we_i(cfgWe), .cfg_cat_i(cfgCat), .cfg_item_i(cfgItem),
    .cfg_price_i(cfgPrice), .cfg_stock_i(cfgStock),
    .credit_o(credit), .coin_reject_o(coinReject), .sel_err_o(selErr),
    .change_valid_o(changeValid), .change_amount_o(changeAmount),
    .refund_valid_o(refundValid), .refund_amount_o(refundAmount),
    .dispense_valid_o(dispenseValid), .dispense_cat_o(dispenseCat),
    .dispense_item_o(dispenseItem), .state_o(state)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: phase number, credit and the price/stock table as plain integers.
  int mState, mCredit, mCat, mItem;
  bit mCoinRej;
  bit modelValid = 0;
  int price [N_CAT][16];
  int stock [N_CAT][16];
`ifdef VEND_TIMEOUT_EN
  localparam int TIMEOUT = 15;
  int mQuiet;
`endif

  function automatic int classify(input int c, input int i);
    if (i == 0 || i >= N_ITEMS || c >= N_CAT) return 1;
    if (price[c][i] == 0) return 1;
    if (stock[c][i] == 0) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin : modelProc
    int nxt;
    int nxtCredit;
    bit accept;
    modelValid = 1;
    if (reset) begin
      mState = 0; mCredit = 0; mCat = 0; mItem = 0; mCoinRej = 0;
      for (int c = 0; c < N_CAT; c++)
        for (int i = 0; i < 16; i++) begin
          price[c][i] = 0;
          stock[c][i] = 0;
        end
`ifdef VEND_TIMEOUT_EN
      mQuiet = 0;
`endif
    end else begin
      accept    = coinValid && (mState == 0 || mState == 1 || mState == 3) &&
                  (mCredit + int'(coinValue) <= MAX_CREDIT);
      mCoinRej  = coinValid && !accept;
      nxtCredit = mCredit + (accept ? int'(coinValue) : 0);
      nxt       = mState;
      if (cfgWe && mState == 0 && int'(cfgItem) < N_ITEMS) begin
        price[cfgCat][cfgItem] = int'(cfgPrice);
        stock[cfgCat][cfgItem] = int'(cfgStock);
      end
      case (mState)
        0: if (accept) nxt = 1;
        1: if (cancel) nxt = 6;
           else if (selValid) begin
             mCat = int'(catSel);
             mItem = int'(itemSel);
             nxt = 2;
           end
        2: if (classify(mCat, mItem) != 0) nxt = 1;
           else if (mCredit > price[mCat][mItem]) nxt = 4;
           else if (mCredit == price[mCat][mItem]) nxt = 5;
           else nxt = 3;
        3: if (cancel) nxt = 6; else if (accept) nxt = 2;
        4: nxt = 5;
        5: begin
             stock[mCat][mItem] = stock[mCat][mItem] - 1;
             nxtCredit = 0;
             nxt = 0;
           end
        default: begin nxtCredit = 0; nxt = 0; end
      endcase
`ifdef VEND_TIMEOUT_EN
      if ((mState == 1 || mState == 3) && !accept && !selValid && !cancel) begin
        mQuiet++;
        if (mQuiet == TIMEOUT) nxt = 6;
      end else mQuiet = 0;
      if (nxt != mState) mQuiet = 0;
`endif
      mState  = nxt;
      mCredit = nxtCredit;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("state", int'(state), mState);
      checkOutput("credit", int'(credit), mCredit);
      checkOutput("coin_reject", int'(coinReject), int'(mCoinRej));
      checkOutput("sel_err", int'(selErr), (mState == 2) ? classify(mCat, mItem) : 0);
      checkOutput("change_valid", int'(changeValid), int'(mState == 4));
      checkOutput("change_amount", int'(changeAmount),
                  (mState == 4) ? mCredit - price[mCat][mItem] : 0);
      checkOutput("refund_valid", int'(refundValid), int'(mState == 6));
      checkOutput("refund_amount", int'(refundAmount), (mState == 6) ? mCredit : 0);
      checkOutput("dispense_valid", int'(dispenseValid), int'(mState == 5));
      checkOutput("dispense_cat", int'(dispenseCat), (mState == 5) ? mCat : 0);
      checkOutput("dispense_item", int'(dispenseItem), (mState == 5) ? mItem : 0);
    end
  end

  task automatic clearInputs();
    coinValid = 0; coinValue = '0; selValid = 0; catSel = '0; itemSel = '0;
    cancel = 0; cfgWe = 0; cfgCat = '0; cfgItem = '0; cfgPrice = '0; cfgStock = '0;
  endtask

  // Drive one cycle of stimulus, let one rising edge sample it, then return to quiet inputs.
  task automatic applyStimulus(input bit cv, input int cval, input bit sv,
                               input int cat, input int item, input bit cn);
    coinValid = cv; coinValue = CW'(cval);
    selValid = sv; catSel = CAT_W'(cat); itemSel = ITEM_W'(item);
    cancel = cn;
    @(negedge clk);
    clearInputs();
  endtask

  task automatic applyConfig(input int cat, input int item, input int p, input int s);
    cfgWe = 1; cfgCat = CAT_W'(cat); cfgItem = ITEM_W'(item);
    cfgPrice = CW'(p); cfgStock = STOCK_W'(s);
    @(negedge clk);
    clearInputs();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int coins [7] = '{5, 10, 20, 25, 50, 100, 500};
    int prices [8] = '{0, 15, 20, 25, 35, 50, 100, 300};
    clearInputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    checkOutput("lit_reset_state", int'(state), 0);
    checkOutput("lit_reset_credit", int'(credit), 0);

    applyConfig(0, 3, 20, 5);
    applyConfig(1, 2, 25, 9);
    applyConfig(0, 4, 35, 3);
    applyConfig(0, 5, 15, 0);

    // Exact price: 10 + 10 for a 20-unit item.
    applyStimulus(1, 10, 0, 0, 0, 0);
    applyStimulus(1, 10, 0, 0, 0, 0);
    checkOutput("lit_credit_20", int'(credit), 20);
    applyStimulus(0, 0, 1, 0, 3, 0);
    checkOutput("lit_exact_check", int'(state), 2);
    idleCycle();
    checkOutput("lit_exact_dispense", int'(dispenseValid), 1);
    checkOutput("lit_exact_no_change", int'(changeValid), 0);
    checkOutput("lit_exact_item", int'(dispenseItem), 3);
    idleCycle();
    checkOutput("lit_exact_credit_clear", int'(credit), 0);

    // Overpay: 50 for a 25-unit item.
    applyStimulus(1, 50, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 2, 0);
    idleCycle();
    checkOutput("lit_over_change_valid", int'(changeValid), 1);
    checkOutput("lit_over_change_amt", int'(changeAmount), 25);
    idleCycle();
    checkOutput("lit_over_dispense", int'(dispenseValid), 1);
    checkOutput("lit_over_cat", int'(dispenseCat), 1);
    idleCycle();

    // Underpay then top up: 20, select 35-unit item, add 20.
    applyStimulus(1, 20, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 4, 0);
    idleCycle();
    checkOutput("lit_pay_more", int'(state), 3);
    applyStimulus(1, 20, 0, 0, 0, 0);
    checkOutput("lit_pay_more_check", int'(state), 2);
    idleCycle();
    checkOutput("lit_topup_change", int'(changeAmount), 5);
    idleCycle();
    checkOutput("lit_topup_dispense", int'(dispenseValid), 1);
    idleCycle();

    // Out-of-stock, reserved item 0, then cancel.
    applyStimulus(1, 10, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 5, 0);
    checkOutput("lit_err_stock", int'(selErr), 2);
    idleCycle();
    checkOutput("lit_err_credit_kept", int'(credit), 10);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("lit_err_invalid", int'(selErr), 1);
    idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("lit_cancel_refund", int'(refundAmount), 10);
    idleCycle();

    // Overflow guard at 1020, then coin + cancel together.
    applyStimulus(1, 500, 0, 0, 0, 0);
    applyStimulus(1, 500, 0, 0, 0, 0);
    applyStimulus(1, 20, 0, 0, 0, 0);
    checkOutput("lit_credit_1020", int'(credit), 1020);
    applyStimulus(1, 10, 0, 0, 0, 0);
    checkOutput("lit_overflow_reject", int'(coinReject), 1);
    checkOutput("lit_overflow_credit", int'(credit), 1020);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idleCycle();
    applyStimulus(1, 30, 0, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0, 1);
    checkOutput("lit_coin_cancel_refund", int'(refundAmount), 35);
    idleCycle();

    // Inactivity behaviour with 10 units of credit.
    applyStimulus(1, 10, 0, 0, 0, 0);
`ifdef VEND_TIMEOUT_EN
    repeat (14) idleCycle();
    checkOutput("lit_timeout_not_yet", int'(state), 1);
    idleCycle();
    checkOutput("lit_timeout_refund_valid", int'(refundValid), 1);
    checkOutput("lit_timeout_refund_amt", int'(refundAmount), 10);
    idleCycle();
`else
    repeat (100) idleCycle();
    checkOutput("lit_no_timeout_state", int'(state), 1);
    checkOutput("lit_no_timeout_credit", int'(credit), 10);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idleCycle();
`endif

    // Randomized traffic, occasional mid-transaction reset.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      cfgWe     = ($urandom_range(0, 5) == 0);
      cfgCat    = CAT_W'($urandom_range(0, N_CAT - 1));
      cfgItem   = ITEM_W'($urandom_range(0, 15));
      cfgPrice  = CW'(prices[$urandom_range(0, 7)]);
      cfgStock  = STOCK_W'($urandom_range(0, 3));
      coinValid = ($urandom_range(0, 2) == 0);
      coinValue = CW'(coins[$urandom_range(0, 6)]);
      selValid  = ($urandom_range(0, 4) == 0);
      catSel    = CAT_W'($urandom_range(0, N_CAT - 1));
      itemSel   = ITEM_W'($urandom_range(0, 11));
      cancel    = ($urandom_range(0, 24) == 0);
      @(negedge clk);
    end
    clearInputs();
    reset = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
